// File: rtl/writeback_buffer_pkg.sv
// Shared types for the writeback buffer: drain FSM states and the stored entry layout.
// Entry field widths here set the buffer's default address and line widths.
package cachepkg;

    localparam int WB_ADDRBITS = 32;
    localparam int WB_LINEBITS = 512;

    typedef enum logic {
        WB_IDLE,
        WB_SEND
    } wb_drain_e;

    typedef struct packed {
        logic                   valid;
        logic [WB_ADDRBITS-1:0] addr;
        logic [WB_LINEBITS-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_buffer_if.sv
// Cache-side, lookup, memory-side and flush signals of the writeback buffer.
interface writeback_buffer_if #(
    parameter int DEPTH    = 4,
    parameter int ADDRBITS = 32,
    parameter int LINEBITS = 512
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                wb_valid;
    logic                wb_ready;
    logic [ADDRBITS-1:0] wb_addr;
    logic [LINEBITS-1:0] wb_data;
    logic [ADDRBITS-1:0] chk_addr;
    logic                chk_hit;
    logic [LINEBITS-1:0] chk_data;
    logic                mem_valid;
    logic                mem_ready;
    logic [ADDRBITS-1:0] mem_addr;
    logic [LINEBITS-1:0] mem_data;
    logic                flush;
    logic                flush_done;
    logic [CW-1:0]       count;

    modport master (
        output wb_valid, wb_addr, wb_data, chk_addr, mem_ready, flush,
        input  wb_ready, chk_hit, chk_data, mem_valid, mem_addr, mem_data, flush_done, count
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, chk_addr, mem_ready, flush,
        output wb_ready, chk_hit, chk_data, mem_valid, mem_addr, mem_data, flush_done, count
    );

endinterface

// File: rtl/writeback_buffer_match.sv
// Address match across the circular buffer, returning the youngest matching slot.
// The head slot can be masked out when it is already offered downstream.
module wb_match #(
    parameter  int DEPTH    = 4,
    parameter  int ADDRBITS = 32,
    localparam int IW       = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]               valid_i,
    input  logic [DEPTH-1:0][ADDRBITS-1:0] addr_i,
    input  logic [IW-1:0]                  head_i,
    input  logic                           skip_head_i,
    input  logic [ADDRBITS-1:0]            key_i,
    output logic                           hit_o,
    output logic [IW-1:0]                  idx_o
);

    logic [IW-1:0] slot;

    // Walk oldest to youngest so the last match found wins.
    always_comb begin
        hit_o = 1'b0;
        idx_o = head_i;
        slot  = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_i + IW'(k);
            if (valid_i[slot] && (addr_i[slot] == key_i) && !(skip_head_i && (k == 0))) begin
                hit_o = 1'b1;
                idx_o = slot;
            end
        end
    end

endmodule

// File: rtl/writeback_buffer.sv
// Writeback buffer: circular FIFO of dirty lines with coalescing, miss lookup and flush drain.
//   state   | meaning
//   WB_IDLE | nothing offered on mem_*, head loaded on the edge after count != 0
//   WB_SEND | head entry held on mem_* until mem_ready pops it
module writeback_buffer
    import cachepkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ADDRBITS = WB_ADDRBITS,
    parameter int LINEBITS = WB_LINEBITS
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    writeback_buffer_if.slave bus
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t     ent_q [DEPTH];
    wb_entry_t     ent_d [DEPTH];
    logic [IW-1:0] head_q, head_d;
    logic [IW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    wb_drain_e     state_q, state_d;
    wb_entry_t     out_q, out_d;
    logic          pend_q, pend_d;
    logic          done_q, done_d;

    logic [DEPTH-1:0]               vld_vec;
    logic [DEPTH-1:0][ADDRBITS-1:0] addr_vec;
    logic                           co_hit, chk_hit;
    logic [IW-1:0]                  co_idx, chk_idx, wr_idx;
    logic [LINEBITS-1:0]            chk_data;
    logic                           wb_ready, enq, append, pop, flush_req;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            vld_vec[i]  = ent_q[i].valid;
            addr_vec[i] = ent_q[i].addr;
        end
    end

    wb_match #(.DEPTH(DEPTH), .ADDRBITS(ADDRBITS)) u_coalesce (
        .valid_i     (vld_vec),
        .addr_i      (addr_vec),
        .head_i      (head_q),
        .skip_head_i (state_q == WB_SEND),
        .key_i       (bus.wb_addr),
        .hit_o       (co_hit),
        .idx_o       (co_idx)
    );

    wb_match #(.DEPTH(DEPTH), .ADDRBITS(ADDRBITS)) u_check (
        .valid_i     (vld_vec),
        .addr_i      (addr_vec),
        .head_i      (head_q),
        .skip_head_i (1'b0),
        .key_i       (bus.chk_addr),
        .hit_o       (chk_hit),
        .idx_o       (chk_idx)
    );

    assign wb_ready       = (count_q != CW'(DEPTH));
    assign chk_data       = chk_hit ? ent_q[chk_idx].data : '0;
    assign bus.wb_ready   = wb_ready;
    assign bus.chk_hit    = chk_hit;
    assign bus.chk_data   = chk_data;
    assign bus.mem_valid  = out_q.valid;
    assign bus.mem_addr   = out_q.addr;
    assign bus.mem_data   = out_q.data;
    assign bus.flush_done = done_q;
    assign bus.count      = count_q;

    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        state_d = state_q;
        out_d   = out_q;

        enq    = bus.wb_valid && wb_ready;
        append = enq && !co_hit;
        pop    = (state_q == WB_SEND) && bus.mem_ready;
        wr_idx = co_hit ? co_idx : tail_q;

        if (pop) begin
            ent_d[head_q].valid = 1'b0;
            head_d              = head_q + 1'b1;
        end
        if (enq) begin
            ent_d[wr_idx] = '{valid: 1'b1, addr: bus.wb_addr, data: bus.wb_data};
        end
        if (append) begin
            tail_d = tail_q + 1'b1;
        end
        count_d = count_q + CW'(append) - CW'(pop);

        // Reload from ent_d so a same-edge write into the next head is forwarded to mem_*.
        case (state_q)
            WB_IDLE: begin
                if (count_q != '0) begin
                    state_d = WB_SEND;
                    out_d   = ent_d[head_q];
                end
            end
            WB_SEND: begin
                if (pop) begin
                    if (count_d != '0) begin
                        out_d = ent_d[head_d];
                    end else begin
                        state_d     = WB_IDLE;
                        out_d.valid = 1'b0;
                    end
                end
            end
        endcase

        flush_req = pend_q || bus.flush;
        done_d    = flush_req && (count_d == '0);
        pend_d    = flush_req && !done_d;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= WB_IDLE;
            out_q   <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
            out_q   <= out_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_writeback_buffer.sv
// Randomized and directed bench for writeback_buffer with a queue-based reference model and write scoreboard.
module tb_writeback_buffer;

    localparam int DEPTH = 4;
    localparam int AB    = 32;
    localparam int LB    = 512;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    writeback_buffer_if #(.DEPTH(DEPTH), .ADDRBITS(AB), .LINEBITS(LB)) bus ();

    writeback_buffer #(.DEPTH(DEPTH), .ADDRBITS(AB), .LINEBITS(LB)) dut (
        .clock_i  (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [AB-1:0] a;
        logic [LB-1:0] d;
    } line_t;

    // Reference model: mq[0] is the oldest line; inflight means mq[0] is being offered downstream.
    line_t mq[$];
    line_t sb[$];
    bit    inflight = 0;
    bit    pend     = 0;
    bit    done_m   = 0;

    int    checks    = 0;
    int    errors    = 0;
    int    done_seen = 0;
    bit    armed     = 0;

    int            exp_count;
    bit            exp_ready, exp_mv, exp_hit, exp_done;
    line_t         exp_front;
    logic [LB-1:0] exp_chk;

    logic [AB-1:0] pool [6] = '{32'h100, 32'h140, 32'h180, 32'h1C0, 32'h200, 32'h240};

    task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LB-1:0] rnd_line();
        logic [LB-1:0] r;
        for (int i = 0; i < LB / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        sb.delete();
        inflight = 0;
        pend     = 0;
        done_m   = 0;
    endtask

    // Snapshot what the DUT should show this cycle, then advance the model across the next edge.
    task automatic model_step();
        int    n;
        int    hit_i;
        bit    f;
        line_t t;
        n         = mq.size();
        exp_count = n;
        exp_ready = (n != DEPTH);
        exp_mv    = inflight;
        exp_done  = done_m;
        if (n > 0) exp_front = mq[0];
        exp_hit = 0;
        exp_chk = '0;
        for (int i = 0; i < n; i++) begin
            if (mq[i].a == bus.chk_addr) begin
                exp_hit = 1;
                exp_chk = mq[i].d;
            end
        end
        armed = 1;

        if (bus.wb_valid && (n != DEPTH)) begin
            hit_i = -1;
            for (int i = (inflight ? 1 : 0); i < n; i++) begin
                if (mq[i].a == bus.wb_addr) hit_i = i;
            end
            if (hit_i >= 0) begin
                t         = mq[hit_i];
                t.d       = bus.wb_data;
                mq[hit_i] = t;
            end else begin
                t.a = bus.wb_addr;
                t.d = bus.wb_data;
                mq.push_back(t);
            end
        end
        if (inflight && bus.mem_ready) begin
            sb.push_back(mq[0]);
            mq.delete(0);
            inflight = (mq.size() != 0);
        end else if (!inflight) begin
            inflight = (n != 0);
        end
        f      = pend || bus.flush;
        done_m = f && (mq.size() == 0);
        pend   = f && !done_m;
    endtask

    task automatic cyc(input logic wv, input logic [AB-1:0] wa, input logic [LB-1:0] wd,
                       input logic mr, input logic fl, input logic [AB-1:0] ca);
        @(negedge clk);
        #1;
        rst_n         = 1'b1;
        bus.wb_valid  = wv;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
        bus.mem_ready = mr;
        bus.flush     = fl;
        bus.chk_addr  = ca;
        model_step();
    endtask

    task automatic idle(input int n, input logic mr, input logic [AB-1:0] ca);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, mr, 1'b0, ca);
    endtask

    // Monitor: per-cycle output comparison plus scoreboard pop on every accepted write.
    initial begin
        line_t e;
        forever begin
            @(negedge clk);
            #2;
            if (armed && rst_n) begin
                check("wb_ready", LB'(bus.wb_ready), LB'(exp_ready));
                check("count", LB'(bus.count), LB'(exp_count));
                check("mem_valid", LB'(bus.mem_valid), LB'(exp_mv));
                if (exp_mv) begin
                    check("mem_addr", LB'(bus.mem_addr), LB'(exp_front.a));
                    check("mem_data", bus.mem_data, exp_front.d);
                end
                check("chk_hit", LB'(bus.chk_hit), LB'(exp_hit));
                check("chk_data", bus.chk_data, exp_chk);
                check("flush_done", LB'(bus.flush_done), LB'(exp_done));
                if (bus.flush_done) done_seen++;
                if (bus.mem_valid && bus.mem_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_write: got write to %0h expected no write", bus.mem_addr);
                    end else begin
                        e = sb.pop_front();
                        check("write_addr", LB'(bus.mem_addr), LB'(e.a));
                        check("write_data", bus.mem_data, e.d);
                    end
                end
            end
        end
    end

    initial begin
        logic [LB-1:0] d1, d2;
        int            d0;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.chk_addr  = '0;
        bus.mem_ready = 1'b0;
        bus.flush     = 1'b0;
        #3;
        check("rst_wb_ready", LB'(bus.wb_ready), LB'(1'b1));
        check("rst_count", LB'(bus.count), '0);
        check("rst_mem_valid", LB'(bus.mem_valid), '0);
        check("rst_mem_addr", LB'(bus.mem_addr), '0);
        check("rst_mem_data", bus.mem_data, '0);
        check("rst_chk_hit", LB'(bus.chk_hit), '0);
        check("rst_chk_data", bus.chk_data, '0);
        check("rst_flush_done", LB'(bus.flush_done), '0);

        // Single line held until mem_ready, then popped.
        cyc(1'b1, 32'h100, rnd_line(), 1'b0, 1'b0, 32'h100);
        idle(5, 1'b0, 32'h100);
        check("hold_mem_valid", LB'(bus.mem_valid), LB'(1'b1));
        check("hold_mem_addr", LB'(bus.mem_addr), LB'(32'h100));
        check("hold_count", LB'(bus.count), LB'(1));
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 32'h100);
        idle(1, 1'b0, 32'h100);
        check("pop_count", LB'(bus.count), '0);
        check("pop_mem_valid", LB'(bus.mem_valid), '0);

        // Fill to capacity, reject a fifth line, drain in order.
        cyc(1'b1, 32'h100, rnd_line(), 1'b0, 1'b0, '0);
        cyc(1'b1, 32'h140, rnd_line(), 1'b0, 1'b0, '0);
        cyc(1'b1, 32'h180, rnd_line(), 1'b0, 1'b0, '0);
        cyc(1'b1, 32'h1C0, rnd_line(), 1'b0, 1'b0, '0);
        cyc(1'b1, 32'h200, rnd_line(), 1'b0, 1'b0, '0);
        check("full_count", LB'(bus.count), LB'(4));
        check("full_wb_ready", LB'(bus.wb_ready), '0);
        idle(1, 1'b0, 32'h200);
        check("full_reject", LB'(bus.chk_hit), '0);
        idle(10, 1'b1, '0);

        // Coalesce behind an in-flight head.
        d1 = rnd_line();
        d2 = rnd_line();
        cyc(1'b1, 32'h100, rnd_line(), 1'b0, 1'b0, 32'h140);
        cyc(1'b1, 32'h140, d1, 1'b0, 1'b0, 32'h140);
        cyc(1'b1, 32'h140, d2, 1'b0, 1'b0, 32'h140);
        idle(1, 1'b0, 32'h140);
        check("coal_count", LB'(bus.count), LB'(2));
        check("coal_chk_data", bus.chk_data, d2);
        idle(6, 1'b1, '0);

        // Same address as the in-flight head becomes a new, younger entry.
        cyc(1'b1, 32'h100, d1, 1'b0, 1'b0, 32'h100);
        idle(2, 1'b0, 32'h100);
        cyc(1'b1, 32'h100, d2, 1'b0, 1'b0, 32'h100);
        idle(1, 1'b0, 32'h100);
        check("dup_count", LB'(bus.count), LB'(2));
        check("dup_chk_data", bus.chk_data, d2);
        idle(6, 1'b1, '0);

        // Flush while empty and idle.
        d0 = done_seen;
        cyc(1'b0, '0, '0, 1'b0, 1'b1, '0);
        idle(3, 1'b0, '0);
        check("flush_empty_pulses", LB'(done_seen - d0), LB'(1));

        // Flush with three queued lines.
        cyc(1'b1, 32'h100, rnd_line(), 1'b0, 1'b0, '0);
        cyc(1'b1, 32'h140, rnd_line(), 1'b0, 1'b0, '0);
        cyc(1'b1, 32'h180, rnd_line(), 1'b0, 1'b0, '0);
        d0 = done_seen;
        cyc(1'b0, '0, '0, 1'b1, 1'b1, '0);
        idle(8, 1'b1, '0);
        check("flush_drain_pulses", LB'(done_seen - d0), LB'(1));

        // Asynchronous reset in the middle of a write.
        cyc(1'b1, 32'h300, rnd_line(), 1'b0, 1'b0, 32'h300);
        cyc(1'b1, 32'h340, rnd_line(), 1'b0, 1'b0, 32'h300);
        idle(2, 1'b0, 32'h300);
        check("pre_rst_mem_valid", LB'(bus.mem_valid), LB'(1'b1));
        check("pre_rst_count", LB'(bus.count), LB'(2));
        #2;
        rst_n = 1'b0;
        armed = 0;
        model_reset();
        #1;
        check("async_rst_mem_valid", LB'(bus.mem_valid), '0);
        check("async_rst_count", LB'(bus.count), '0);
        check("async_rst_wb_ready", LB'(bus.wb_ready), LB'(1'b1));
        check("async_rst_chk_hit", LB'(bus.chk_hit), '0);

        // First edge after release accepts a line.
        cyc(1'b1, 32'h240, rnd_line(), 1'b0, 1'b0, 32'h240);
        idle(1, 1'b0, 32'h240);
        check("post_rst_count", LB'(bus.count), LB'(1));

        for (int c = 0; c < 3000; c++) begin
            cyc(($urandom_range(0, 9) < 6), pool[$urandom_range(0, 5)], rnd_line(),
                1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0), pool[$urandom_range(0, 5)]);
        end

        for (int c = 0; c < 40 && (mq.size() != 0 || inflight); c++) cyc(1'b0, '0, '0, 1'b1, 1'b0, '0);
        idle(2, 1'b0, '0);
        check("final_count", LB'(bus.count), '0);
        check("final_pending_writes", LB'(sb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
